// File: rtl/uart_txq.sv
// uart_txq: byte FIFO feeding a uart_tx transmitter through a write/idle
// handshake. Each queued byte becomes one frame on the transmitter.
// Optional feature: define UART_TXQ_OVF_EN to add the sticky 'ovf' output
// that flags pushes dropped because the queue was full.
module uart_txq #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          setb,
  input  logic          push,
  input  logic [7:0]    wdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic [7:0]    tx_data,
  output logic          tx_write,
  input  logic          tx_idle,
`ifdef UART_TXQ_OVF_EN
  output logic          ovf,
`endif
  output logic          busy
);

  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_ARM  = 2'd1,
    Q_BUSY = 2'd2
  } q_state_e;

  q_state_e      r_state;
  q_state_e      w_state_nxt;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_tx_data;
  logic          r_tx_write;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_tx_write_nxt;

  // Full is judged on the registered level, so a pop in the same cycle
  // never makes room for a push that arrives while full.
  assign w_full  = (r_level == L_DEPTH);
  assign w_empty = (r_level == '0);
  assign w_push  = setb & push & ~w_full;

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign tx_data  = r_tx_data;
  assign tx_write = r_tx_write;
  assign busy     = (r_state != Q_IDLE) | ~w_empty;

  // State register for the transmit handshake FSM
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= Q_IDLE;
    end else if (setb) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: pop only when idle, wait for the transmitter to go
  // busy, then wait for it to finish the frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      Q_IDLE:  if (!w_empty && tx_idle) w_state_nxt = Q_ARM;
      Q_ARM:   if (!tx_idle)            w_state_nxt = Q_BUSY;
      Q_BUSY:  if (tx_idle)             w_state_nxt = Q_IDLE;
      default:                          w_state_nxt = Q_IDLE;
    endcase
  end

  // Output decode: pop strobe and the next value of the registered write
  // request. tx_write rises one cycle after the pop, giving the pop cycle
  // plus the first ARM cycle as the minimum low time between frames.
  always_comb begin
    w_pop          = 1'b0;
    w_tx_write_nxt = r_tx_write;
    if (setb) begin
      case (r_state)
        Q_IDLE: begin
          w_pop          = !w_empty && tx_idle;
          w_tx_write_nxt = 1'b0;
        end
        Q_ARM:   w_tx_write_nxt = tx_idle;
        Q_BUSY:  w_tx_write_nxt = 1'b0;
        default: w_tx_write_nxt = 1'b0;
      endcase
    end
  end

  // FIFO storage; no reset, entries are meaningless until written
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers and level; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + P_ONE;
      if (w_pop)  r_rptr <= r_rptr + P_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + L_ONE;
        2'b01:   r_level <= r_level - L_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Registered transmitter interface; tx_data only changes on a pop
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_tx_data  <= '0;
      r_tx_write <= 1'b0;
    end else begin
      if (w_pop) r_tx_data <= r_mem[r_rptr];
      r_tx_write <= w_tx_write_nxt;
    end
  end

`ifdef UART_TXQ_OVF_EN
  logic r_ovf;

  // Sticky flag for pushes dropped while full; only reset clears it
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ovf <= 1'b0;
    end else if (setb && push && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_txq.sv
// Self-checking bench for uart_txq: a per-cycle vector table for the single
// byte and fill-to-full cases, plus directed sequences for pointer wrap,
// setb freeze, mid-frame reset and a loop through a simple uart_tx model.
module tb_uart_txq;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstb;
  logic          setb;
  logic          push;
  logic [7:0]    wdata;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic [7:0]    tx_data;
  logic          tx_write;
  logic          tx_idle;
  logic          busy;
  logic          tx_idle_tb;
  logic          use_model;
`ifdef UART_TXQ_OVF_EN
  logic          ovf;
`endif

  always #5 clk = ~clk;

  uart_txq #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .setb     (setb),
    .push     (push),
    .wdata    (wdata),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_data  (tx_data),
    .tx_write (tx_write),
    .tx_idle  (tx_idle),
`ifdef UART_TXQ_OVF_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- uart_tx model: div=3, 8N1, LSB first ----------------
  logic       m_busy = 1'b0;
  logic [9:0] m_sh   = '1;
  int         m_div  = 0;
  int         m_bit  = 0;
  logic       m_line;
  assign m_line  = m_busy ? m_sh[0] : 1'b1;
  assign tx_idle = use_model ? ~m_busy : tx_idle_tb;

  always @(posedge clk) begin
    if (!m_busy) begin
      if (use_model && tx_write) begin
        m_busy <= 1'b1;
        m_sh   <= {1'b1, tx_data, 1'b0};
        m_div  <= 0;
        m_bit  <= 0;
      end
    end else if (m_div == 2) begin
      m_div <= 0;
      m_sh  <= {1'b1, m_sh[9:1]};
      if (m_bit == 9) m_busy <= 1'b0;
      else            m_bit  <= m_bit + 1;
    end else begin
      m_div <= m_div + 1;
    end
  end

  // Serial decoder: samples mid-bit on negedges after the start edge
  logic       rx_act = 1'b0;
  int         rx_n   = 0;
  logic [7:0] rx_sh  = '0;
  logic [7:0] rx_mem [64];
  int         rx_cnt = 0;
  int         rx_err = 0;

  always @(negedge clk) begin
    if (!rx_act) begin
      if (m_line == 1'b0) begin
        rx_act <= 1'b1;
        rx_n   <= 0;
      end
    end else begin
      if (((rx_n + 1) % 3 == 1) && (rx_n + 1 >= 4) && (rx_n + 1 <= 25))
        rx_sh <= {m_line, rx_sh[7:1]};
      if (rx_n + 1 == 28) begin
        if (rx_cnt < 64) rx_mem[rx_cnt] <= rx_sh;
        rx_cnt <= rx_cnt + 1;
        if (m_line != 1'b1) rx_err <= rx_err + 1;
        rx_act <= 1'b0;
      end
      rx_n <= rx_n + 1;
    end
  end

  // tx_write rising-edge monitor capturing tx_data
  logic       prev_w = 1'b0;
  logic [7:0] cap_mem [64];
  int         cap_n  = 0;

  always @(negedge clk) begin
    prev_w <= tx_write;
    if (tx_write && !prev_w) begin
      if (cap_n < 64) cap_mem[cap_n] <= tx_data;
      cap_n <= cap_n + 1;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          setb;
    logic          push;
    logic [7:0]    wdata;
    logic          idle;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          txw;
    logic [7:0]    txd;
    logic          busy;
  } vec_t;

  vec_t vt [17];

  // Manual handshake for one frame; returns the popped byte, leaves FSM in Q_BUSY
  task automatic pop_one(input string name, output logic [7:0] d);
    int n;
    tx_idle_tb = 1'b1;
    n = 0;
    while (tx_write !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({name, ".write_seen"}, int'(tx_write === 1'b1), 1);
    d = tx_data;
    @(negedge clk);
    tx_idle_tb = 1'b0;
    n = 0;
    while (tx_write !== 1'b0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({name, ".write_drop"}, int'(tx_write === 1'b0), 1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] exp8 [8];
    int         base_c;
    int         base_r;
    int         n;

    // single byte through the handshake, one vector per clock
    vt[0] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, LW'(1), 1'b0, 8'h00, 1'b1};
    vt[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(0), 1'b0, 8'hA5, 1'b1};
    vt[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(0), 1'b1, 8'hA5, 1'b1};
    vt[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(0), 1'b1, 8'hA5, 1'b1};
    vt[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, LW'(0), 1'b0, 8'hA5, 1'b1};
    vt[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, LW'(0), 1'b0, 8'hA5, 1'b1};
    vt[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, LW'(0), 1'b0, 8'hA5, 1'b0};
    vt[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, LW'(0), 1'b0, 8'hA5, 1'b0};
    // fill to full with the transmitter held busy; ninth push dropped
    for (int k = 0; k < 9; k++) begin
      vt[8 + k] = '{1'b1, 1'b1, 8'(k), 1'b0, (k >= 7), 1'b0,
                    (k >= 7) ? LW'(8) : LW'(k + 1), 1'b0, 8'hA5, 1'b1};
    end

    rstb = 1'b0; setb = 1'b0; push = 1'b0; wdata = '0;
    tx_idle_tb = 1'b0; use_model = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.full", full, 0);
    chk("rst.empty", empty, 1);
    chk("rst.level", level, 0);
    chk("rst.tx_write", tx_write, 0);
    chk("rst.tx_data", tx_data, 0);
    chk("rst.busy", busy, 0);
`ifdef UART_TXQ_OVF_EN
    chk("rst.ovf", ovf, 0);
`endif
    @(negedge clk);
    rstb = 1'b1;

    for (int i = 0; i < 17; i++) begin
      setb = vt[i].setb; push = vt[i].push; wdata = vt[i].wdata; tx_idle_tb = vt[i].idle;
      @(posedge clk); #1;
      chk($sformatf("v%0d.full", i), full, vt[i].full);
      chk($sformatf("v%0d.empty", i), empty, vt[i].empty);
      chk($sformatf("v%0d.level", i), level, vt[i].level);
      chk($sformatf("v%0d.tx_write", i), tx_write, vt[i].txw);
      chk($sformatf("v%0d.tx_data", i), tx_data, vt[i].txd);
      chk($sformatf("v%0d.busy", i), busy, vt[i].busy);
      @(negedge clk);
    end
    push = 1'b0;
`ifdef UART_TXQ_OVF_EN
    chk("fill.ovf", ovf, 1);
`endif

    // drain 5 of 00..07, push 6 more across the wrap, 6th dropped
    for (int k = 0; k < 5; k++) begin
      pop_one("wrap.a", d);
      chk($sformatf("wrap.a%0d.data", k), d, k);
    end
    @(posedge clk); #1;
    chk("wrap.level3", level, 3);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      push = 1'b1; wdata = 8'(8'h30 + k);
      @(posedge clk); #1;
      chk($sformatf("wrap.push%0d.level", k), level, (4 + k > 8) ? 8 : 4 + k);
      @(negedge clk);
    end
    push = 1'b0;
    chk("wrap.full", full, 1);
    exp8 = '{8'h05, 8'h06, 8'h07, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    for (int k = 0; k < 8; k++) begin
      pop_one("wrap.b", d);
      chk($sformatf("wrap.b%0d.data", k), d, exp8[k]);
    end
    chk("wrap.empty", empty, 1);
    chk("wrap.level0", level, 0);
    tx_idle_tb = 1'b1;
    repeat (3) @(negedge clk);
    chk("wrap.busy_end", busy, 0);

    // setb=0 for 10 clk during Q_BUSY with push asserted
    tx_idle_tb = 1'b0;
    push = 1'b1; wdata = 8'h5A;
    @(negedge clk);
    push = 1'b0;
    pop_one("frz.a", d);
    chk("frz.first", d, 8'h5A);
    push = 1'b1; wdata = 8'h66;
    @(negedge clk);
    push = 1'b0;
    chk("frz.level_pre", level, 1);
    setb = 1'b0; push = 1'b1; wdata = 8'h99; tx_idle_tb = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("frz%0d.level", k), level, 1);
      chk($sformatf("frz%0d.tx_data", k), tx_data, 8'h5A);
      chk($sformatf("frz%0d.tx_write", k), tx_write, 0);
      chk($sformatf("frz%0d.busy", k), busy, 1);
    end
    @(negedge clk);
    setb = 1'b1; push = 1'b0; tx_idle_tb = 1'b0;
    pop_one("frz.b", d);
    chk("frz.second", d, 8'h66);
    chk("frz.empty", empty, 1);
    tx_idle_tb = 1'b1;
    repeat (3) @(negedge clk);

    // reset pulsed while in Q_ARM
    tx_idle_tb = 1'b0;
    push = 1'b1; wdata = 8'h41;
    @(negedge clk);
    wdata = 8'h42;
    @(negedge clk);
    push = 1'b0;
    tx_idle_tb = 1'b1;
    n = 0;
    while (tx_write !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("arm.reached", int'(tx_write === 1'b1), 1);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("arm_rst.tx_write", tx_write, 0);
    chk("arm_rst.empty", empty, 1);
    chk("arm_rst.level", level, 0);
    chk("arm_rst.busy", busy, 0);
    chk("arm_rst.tx_data", tx_data, 0);
`ifdef UART_TXQ_OVF_EN
    chk("arm_rst.ovf", ovf, 0);
`endif
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;
    base_c = cap_n;
    repeat (20) @(posedge clk);
    #1;
    chk("arm_rst.no_write", cap_n - base_c, 0);
    @(negedge clk);
    push = 1'b1; wdata = 8'h77;
    @(negedge clk);
    push = 1'b0;
    n = 0;
    while (tx_write !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("arm_rst.new_write", int'(tx_write === 1'b1), 1);
    chk("arm_rst.new_data", tx_data, 8'h77);
    @(negedge clk);
    tx_idle_tb = 1'b0;
    repeat (2) @(negedge clk);
    tx_idle_tb = 1'b1;
    repeat (3) @(negedge clk);
    chk("arm_rst.busy_end", busy, 0);

    // loop through the uart_tx model: three back-to-back pushes
    use_model = 1'b1;
    @(posedge clk); #1;
    base_c = cap_n;
    base_r = rx_cnt;
    @(negedge clk);
    push = 1'b1; wdata = 8'h11;
    @(negedge clk);
    wdata = 8'h22;
    @(negedge clk);
    wdata = 8'h33;
    @(negedge clk);
    push = 1'b0;
    n = 0;
    while (!((rx_cnt - base_r == 3) && !busy && !m_busy) && n < 600) begin
      @(posedge clk); #1; n++;
    end
    chk("uart.done", int'(n < 600), 1);
    chk("uart.edges", cap_n - base_c, 3);
    chk("uart.frames", rx_cnt - base_r, 3);
    chk("uart.stop_err", rx_err, 0);
    exp8[0] = 8'h11; exp8[1] = 8'h22; exp8[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("uart.tx_data%0d", k), cap_mem[base_c + k], exp8[k]);
      chk($sformatf("uart.rx%0d", k), rx_mem[base_r + k], exp8[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
